// File: rtl/phrase_streamer.sv
// Streams a ROM phrase byte-by-byte over valid/ready; latches cur_num on finish.
// Optional CRLF_EN appends 0D 0A after the phrase.
module phrase_streamer #(
  parameter logic [2:0] START_NUM  = 3'd0,
  parameter int         GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] phrase_num,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] cur_num
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
`ifdef CRLF_EN
    TERM,
`endif
    DONE
  } state_t;

  localparam logic       NO_GAP = (GAP_CYCLES == 0);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        num_q, num_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        gap_q, gap_d;
  logic [2:0]        cur_q, cur_d;
  logic [0:15][7:0]  row;
  logic [3:0]        len;
  logic [3:0]        idx_nx;
  logic [7:0]        phr_char;
`ifdef CRLF_EN
  logic              term_q, term_d;
`endif

  // Rows are left-aligned so byte k of the row is character k.
  always_comb begin
    unique case (num_q)
      3'd0: begin row = {"HELLO WORLD", 40'd0};   len = 4'd11; end
      3'd1: begin row = {"HOW YOU DOIN", 32'd0};  len = 4'd12; end
      3'd2: begin row = {"HEY", 104'd0};          len = 4'd3;  end
      3'd3: begin row = {"SUP", 104'd0};          len = 4'd3;  end
      3'd4: begin row = {"GMORNING", 64'd0};      len = 4'd8;  end
      3'd5: begin row = {"WHAT IS LIFE", 32'd0};  len = 4'd12; end
      3'd6: begin row = {"ARGGGG", 80'd0};        len = 4'd6;  end
      default: begin row = {"I NEED H2O", 48'd0}; len = 4'd10; end
    endcase
    phr_char = row[idx_q];
    idx_nx   = idx_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    cur_d      = cur_q;
    char_valid = 1'b0;
    char_data  = 8'h00;
`ifdef CRLF_EN
    term_d     = term_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = phrase_num;
          idx_d   = 4'd0;
          state_d = SEND;
`ifdef CRLF_EN
          term_d  = 1'b0;
`endif
        end
      end
      SEND: begin
        char_valid = 1'b1;
        char_data  = phr_char;
        if (char_ready) begin
          idx_d = idx_nx;
          if (idx_nx == len) begin
`ifdef CRLF_EN
            if (NO_GAP) begin
              state_d = TERM;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LD;
            end
`else
            state_d = DONE;
            cur_d   = num_q;
`endif
          end else if (!NO_GAP) begin
            state_d = GAP;
            gap_d   = GAP_LD;
          end
        end
      end
      GAP: begin
        if (gap_q == 8'd0) begin
`ifdef CRLF_EN
          state_d = (idx_q == len) ? TERM : SEND;
`else
          state_d = SEND;
`endif
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
`ifdef CRLF_EN
      TERM: begin
        char_valid = 1'b1;
        char_data  = term_q ? 8'h0A : 8'h0D;
        if (char_ready) begin
          if (term_q) begin
            state_d = DONE;
            cur_d   = num_q;
          end else begin
            term_d = 1'b1;
            if (!NO_GAP) begin
              state_d = GAP;
              gap_d   = GAP_LD;
            end
          end
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    cur_num = cur_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= 3'd0;
      idx_q   <= 4'd0;
      gap_q   <= 8'd0;
      cur_q   <= START_NUM;
`ifdef CRLF_EN
      term_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cur_q   <= cur_d;
`ifdef CRLF_EN
      term_q  <= term_d;
`endif
    end
  end

endmodule

// File: tb/tb_phrase_streamer.sv
// Bench for phrase_streamer: table of phrases plus gap, abort
// and ignored-start sequences, bytes checked through a scoreboard.
module tb_phrase_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start3;
  logic       char_ready;
  logic [2:0] phrase_num;
  logic [7:0] data0, data3;
  logic       valid0, valid3;
  logic       busy0, busy3;
  logic       done0, done3;
  logic [2:0] cur0, cur3;

  always #5 clk = ~clk;

  phrase_streamer #(.START_NUM(3'd5), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .phrase_num(phrase_num), .char_data(data0),
    .char_valid(valid0), .char_ready(char_ready),
    .busy(busy0), .done(done0), .cur_num(cur0)
  );

  phrase_streamer #(.START_NUM(3'd0), .GAP_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .start(start3),
    .phrase_num(phrase_num), .char_data(data3),
    .char_valid(valid3), .char_ready(char_ready),
    .busy(busy3), .done(done3), .cur_num(cur3)
  );

  typedef struct {
    logic [2:0] num;
    string      txt;
    int         mode;
  } vec_t;

  int         n_pass = 0;
  int         n_tot  = 0;
  logic [7:0] q0[$];
  logic [7:0] q3[$];
  int         fire0  = 0;
  int         dones0 = 0;
  logic       stall0 = 1'b0;
  logic       stall3 = 1'b0;
  logic [7:0] hold0, hold3;
  vec_t       tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic miss(input string nm, input int act);
    n_tot++;
    $display("FAIL %s: got %0h want none", nm, act);
  endtask

  // Scoreboard: a transfer is predicted when valid && ready before the edge.
  always @(negedge clk) begin
    if (valid0 && char_ready) begin
      fire0 <= fire0 + 1;
      if (q0.size() == 0) miss("byte0_extra", data0);
      else chk("byte0", data0, q0.pop_front());
    end
    if (valid3 && char_ready) begin
      if (q3.size() == 0) miss("byte3_extra", data3);
      else chk("byte3", data3, q3.pop_front());
    end
    if (stall0) chk("hold0", {valid0, data0}, {1'b1, hold0});
    if (stall3) chk("hold3", {valid3, data3}, {1'b1, hold3});
    stall0 <= valid0 && !char_ready && !rst;
    stall3 <= valid3 && !char_ready && !rst;
    hold0  <= data0;
    hold3  <= data3;
    if (done0) dones0 <= dones0 + 1;
  end

  task automatic push_txt0(input string txt);
    for (int i = 0; i < txt.len(); i++) q0.push_back(txt[i]);
`ifdef CRLF_EN
    q0.push_back(8'h0D);
    q0.push_back(8'h0A);
`endif
  endtask

  task automatic run_phrase(input logic [2:0] num, input string txt,
                            input int mode, input int poke);
    int tot;
    int cyc;
    int d0;
    bit seen;
    tot = txt.len();
`ifdef CRLF_EN
    tot += 2;
`endif
    seen = 0;
    d0   = dones0;
    push_txt0(txt);
    char_ready = 1'b1;
    phrase_num = num;
    start0     = 1'b1;
    @(posedge clk); #1;
    start0     = 1'b0;
    phrase_num = ~num;
    cyc = 1;
    chk("first_valid", valid0, 1);
    while (!seen && cyc < 300) begin
      chk("busy_run", busy0, 1);
      if (done0) begin
        seen = 1;
        chk("done_cur", cur0, num);
        chk("done_valid", valid0, 0);
        if (mode == 0) chk("done_cyc", cyc, tot + 1);
      end else begin
        if (cyc == poke) begin
          start0     = 1'b1;
          phrase_num = 3'd4;
        end else begin
          start0 = 1'b0;
        end
        if (mode == 1) char_ready = (cyc % 3 == 0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start0 = 1'b0;
    if (!seen) miss("done_timeout", cyc);
    char_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy0, 0);
    chk("idle_done", done0, 0);
    chk("idle_valid", valid0, 0);
    chk("done_count", dones0 - d0, 1);
    chk("q0_empty", q0.size(), 0);
  endtask

  initial begin
    int nb;
    int span;
    int f0;
    int d0;
    int k;
    tbl[0] = '{3'd2, "HEY", 0};
    tbl[1] = '{3'd6, "ARGGGG", 1};
    tbl[2] = '{3'd0, "HELLO WORLD", 1};
    tbl[3] = '{3'd5, "WHAT IS LIFE", 0};
    tbl[4] = '{3'd7, "I NEED H2O", 1};
    tbl[5] = '{3'd3, "SUP", 0};
    tbl[6] = '{3'd4, "GMORNING", 1};
    tbl[7] = '{3'd1, "HOW YOU DOIN", 0};

    rst = 1'b1;
    start0 = 1'b0;
    start3 = 1'b0;
    char_ready = 1'b1;
    phrase_num = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", valid0, 0);
    chk("rst_data0", data0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_cur0", cur0, 5);
    chk("rst_cur3", cur3, 0);
    chk("rst_valid3", valid3, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Gap instance: 3 idle cycles between every accepted byte
    q3.push_back("S");
    q3.push_back("U");
    q3.push_back("P");
    nb = 3;
`ifdef CRLF_EN
    q3.push_back(8'h0D);
    q3.push_back(8'h0A);
    nb = 5;
`endif
    span = (nb - 1) * 4 + 1;
    phrase_num = 3'd3;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int c = 1; c <= span; c++) begin
      chk("gap_valid", valid3, int'((c - 1) % 4 == 0));
      chk("gap_busy", busy3, 1);
      chk("gap_done", done3, 0);
      @(posedge clk); #1;
    end
    chk("gap_done_pulse", done3, 1);
    chk("gap_cur", cur3, 3);
    @(posedge clk); #1;
    chk("gap_idle", busy3, 0);
    chk("q3_empty", q3.size(), 0);

    for (int i = 0; i < 8; i++)
      run_phrase(tbl[i].num, tbl[i].txt, tbl[i].mode, -1);

    // Restart attempt mid-phrase must be ignored
    run_phrase(3'd1, "HOW YOU DOIN", 0, 4);
    run_phrase(3'd4, "GMORNING", 0, -1);

    // Abort phrase 0 after its 5th byte
    push_txt0("HELLO WORLD");
    f0 = fire0;
    d0 = dones0;
    phrase_num = 3'd0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    k = 0;
    while (fire0 - f0 < 5 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_reach", fire0 - f0, 5);
    rst = 1'b1;
    char_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", valid0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_cur", cur0, 5);
    chk("abort_data", data0, 0);
    rst = 1'b0;
    char_ready = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    chk("abort_nodone", dones0 - d0, 0);
    chk("abort_idle", busy0, 0);
    run_phrase(3'd7, "I NEED H2O", 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
